// File: rtl/vm_pkg.sv
// Shared definitions for the Sv32 page-table walker.
// Holds the PTE bit positions, the access-type and fault-code encodings,
// and the walker state enum.
package vm_pkg;

    // PTE bit positions
    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 31;

    // Access types; encoding 3 is reserved and behaves as a load
    localparam logic [1:0] ACC_LOAD  = 2'd0;
    localparam logic [1:0] ACC_STORE = 2'd1;
    localparam logic [1:0] ACC_FETCH = 2'd2;

    // Fault codes
    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_INVALID  = 2'd1;
    localparam logic [1:0] FAULT_PERM     = 2'd2;
    localparam logic [1:0] FAULT_MISALIGN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WB_REQ,
        ST_RESP
    } walk_state_t;

endpackage

// File: rtl/pte_checker.sv
// Combinational decode and permission check of one Sv32 PTE.
// Ports:
//   pte      in  32  PTE as read from memory
//   access   in  2   access type (load/store/fetch; 3 acts as load)
//   user     in  1   request from user mode
//   level    in  1   walk level the PTE was read at (1 = root)
//   leaf     out 1   PTE is a leaf (R or X set)
//   fault    out 2   fault code, FAULT_NONE when the walk may continue
//   needs_wb out 1   leaf is good but A (or D on store) must be set
//   new_pte  out 32  PTE with A/D bits merged in
module pte_checker
    import vm_pkg::*;
(
    input  logic [31:0] pte,
    input  logic [1:0]  access,
    input  logic        user,
    input  logic        level,
    output logic        leaf,
    output logic [1:0]  fault,
    output logic        needs_wb,
    output logic [31:0] new_pte
);

    logic is_store;
    logic is_fetch;
    logic perm_ok;
    logic user_ok;

    always_comb begin
        is_store = (access == ACC_STORE);
        is_fetch = (access == ACC_FETCH);
        leaf     = pte[PTE_R] | pte[PTE_X];
        perm_ok  = is_store ? pte[PTE_W] : (is_fetch ? pte[PTE_X] : pte[PTE_R]);
        // user pages are reachable only from user mode and vice versa
        user_ok  = (user == pte[PTE_U]);

        fault = FAULT_NONE;
        if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
            fault = FAULT_INVALID;
        end else if (!leaf) begin
            // a pointer is only legal at the root level
            if (!level) fault = FAULT_INVALID;
        end else if (level && (pte[PTE_PPN_LSB+9:PTE_PPN_LSB] != 10'd0)) begin
            fault = FAULT_MISALIGN;
        end else if (!perm_ok || !user_ok) begin
            fault = FAULT_PERM;
        end

        new_pte = pte;
        new_pte[PTE_A] = 1'b1;
        if (is_store) new_pte[PTE_D] = 1'b1;

        needs_wb = (fault == FAULT_NONE) && leaf &&
                   (!pte[PTE_A] || (is_store && !pte[PTE_D]));
    end

endmodule

// File: rtl/sv32_page_walker.sv
// Sv32 two-level hardware page-table walker.
// Accepts a VPN walk request, reads the root and (if needed) leaf PTE,
// checks the leaf, writes back A/D when required and returns PPN or fault.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           walk request handshake
//   req_vpn, req_access, req_user request fields; satp_ppn root table PPN
//   mem_req_valid/mem_req_ready   memory request handshake
//   mem_req_addr/we/wdata         memory request fields (byte address)
//   mem_rsp_valid, mem_rsp_data   read data pulse
//   resp_valid/resp_ready         result handshake
//   resp_ppn, resp_superpage, resp_fault, resp_pte   result fields
//
// state      | meaning
// IDLE       | waiting for a walk request
// RD_REQ     | PTE read request presented to memory
// RD_WAIT    | read accepted, waiting for PTE data
// WB_REQ     | A/D write-back presented to memory
// RESP       | result held until consumed
module sv32_page_walker
    import vm_pkg::*;
#(
    parameter int PA_WIDTH  = 34,
    parameter int PPN_WIDTH = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [19:0]          req_vpn,
    input  logic [1:0]           req_access,
    input  logic                 req_user,
    input  logic [PPN_WIDTH-1:0] satp_ppn,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [PA_WIDTH-1:0]  mem_req_addr,
    output logic                 mem_req_we,
    output logic [31:0]          mem_req_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [PPN_WIDTH-1:0] resp_ppn,
    output logic                 resp_superpage,
    output logic [1:0]           resp_fault,
    output logic [31:0]          resp_pte
);

    walk_state_t state;
    logic [19:0] vpn_q;
    logic [1:0]  access_q;
    logic        user_q;
    logic        level_q;

    logic        chk_leaf;
    logic [1:0]  chk_fault;
    logic        chk_needs_wb;
    logic [31:0] chk_new_pte;

    pte_checker u_pte_checker (
        .pte      (mem_rsp_data),
        .access   (access_q),
        .user     (user_q),
        .level    (level_q),
        .leaf     (chk_leaf),
        .fault    (chk_fault),
        .needs_wb (chk_needs_wb),
        .new_pte  (chk_new_pte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vpn_q          <= '0;
            access_q       <= '0;
            user_q         <= 1'b0;
            level_q        <= 1'b0;
            req_ready      <= 1'b1;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_we     <= 1'b0;
            mem_req_wdata  <= '0;
            resp_valid     <= 1'b0;
            resp_ppn       <= '0;
            resp_superpage <= 1'b0;
            resp_fault     <= FAULT_NONE;
            resp_pte       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        vpn_q         <= req_vpn;
                        access_q      <= req_access;
                        user_q        <= req_user;
                        level_q       <= 1'b1;
                        req_ready     <= 1'b0;
                        // satp only matters for the root address, so it is
                        // folded into the address here instead of being kept
                        mem_req_addr  <= PA_WIDTH'({satp_ppn, req_vpn[19:10], 2'b00});
                        mem_req_we    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        resp_pte <= mem_rsp_data;
                        if (chk_fault != FAULT_NONE) begin
                            resp_fault     <= chk_fault;
                            resp_ppn       <= '0;
                            resp_superpage <= 1'b0;
                            resp_valid     <= 1'b1;
                            state          <= ST_RESP;
                        end else if (!chk_leaf) begin
                            level_q       <= 1'b0;
                            mem_req_addr  <= PA_WIDTH'({mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB],
                                                        vpn_q[9:0], 2'b00});
                            mem_req_valid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end else begin
                            resp_fault     <= FAULT_NONE;
                            resp_superpage <= level_q;
                            resp_pte       <= chk_new_pte;
                            resp_ppn       <= level_q
                                ? PPN_WIDTH'({mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB+10], vpn_q[9:0]})
                                : PPN_WIDTH'(mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB]);
                            if (chk_needs_wb) begin
                                // address register still holds this PTE's address
                                mem_req_we    <= 1'b1;
                                mem_req_wdata <= chk_new_pte;
                                mem_req_valid <= 1'b1;
                                state         <= ST_WB_REQ;
                            end else begin
                                resp_valid <= 1'b1;
                                state      <= ST_RESP;
                            end
                        end
                    end
                end
                ST_WB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_we    <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
